// File: rtl/ext_mem_write_arbiter.sv
// rtl/ext_mem_write_arbiter.sv - round-robin arbiter/sequencer for the shared EXT_MEM write port
//
// Purpose: lets N_REQ write requesters share one EXT_MEM write port. One winner
// is chosen round-robin, its address/payload are latched, a one-cycle start
// pulse is issued, completion (or a watchdog expiry) is awaited, and a one-cycle
// done pulse is returned to the owner.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req[N_REQ]             per-requester level request
//   i_addr[32*N_REQ]         requester k address at [32k+31:32k]
//   i_payload[64*N_REQ]      requester k payload at [64k+63:64k]
//   o_grant[N_REQ]           one-hot current owner
//   o_done[N_REQ]            one-cycle completion pulse to the owner
//   EXT_MEM_writeTxnDone     completion from the memory master
//   EXT_MEM_writeAddress     latched address
//   EXT_MEM_writePayload     latched payload
//   EXT_MEM_initWriteTxn     one-cycle start pulse
//   o_busy                   high whenever not idle
//   o_timeout                sticky watchdog error
//   o_txn_count              genuinely completed transactions (wraps)
module ext_mem_write_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [32*N_REQ-1:0]   i_addr,
    input  logic [64*N_REQ-1:0]   i_payload,
    output logic [N_REQ-1:0]      o_grant,
    output logic [N_REQ-1:0]      o_done,
    input  logic                  EXT_MEM_writeTxnDone,
    output logic [31:0]           EXT_MEM_writeAddress,
    output logic [63:0]           EXT_MEM_writePayload,
    output logic                  EXT_MEM_initWriteTxn,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic [31:0]           o_txn_count
);

    localparam int PW = (N_REQ > 2) ? 2 : 1;
    localparam logic [PW:0] SUM_N = (PW+1)'(N_REQ);
    localparam logic [31:0] WAIT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [31:0]       addr_q, addr_d;
    logic [63:0]       payload_q, payload_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       wait_q, wait_d;

    // Round-robin pick: rotate requests so the pointer sits at bit 0, take the
    // lowest set bit, then rotate the offset back to an absolute index.
    logic [2*N_REQ-1:0] req_rot;
    logic               found;
    logic [PW-1:0]      win_off;
    logic [PW:0]        win_sum;
    logic [PW-1:0]      win_idx;
    logic [N_REQ-1:0]   win_onehot;
    logic [31:0]        sel_addr;
    logic [63:0]        sel_payload;

    assign req_rot = {i_req, i_req} >> ptr_q;

    always_comb begin
        found       = 1'b0;
        win_off     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found   = 1'b1;
                win_off = PW'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= SUM_N) begin
            win_sum = win_sum - SUM_N;
        end
        win_idx     = win_sum[PW-1:0];
        win_onehot  = '0;
        sel_addr    = '0;
        sel_payload = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == PW'(k)) begin
                win_onehot[k] = 1'b1;
                sel_addr      = i_addr[k*32 +: 32];
                sel_payload   = i_payload[k*64 +: 64];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        wait_d    = wait_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d   = win_onehot;
                    owner_d   = win_idx;
                    addr_d    = sel_addr;
                    payload_d = sel_payload;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d = '0;
                if (EXT_MEM_writeTxnDone) begin
                    count_d = count_q + 32'd1;
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (EXT_MEM_writeTxnDone) begin
                    count_d = count_q + 32'd1;
                    state_d = S_RELEASE;
                end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
                    // Abandoned transaction: owner still gets its done pulse,
                    // but it is not counted as completed.
                    timeout_d = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_RELEASE: begin
                grant_d = '0;
                ptr_d   = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            payload_q <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            payload_q <= payload_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
        end
    end

    assign o_grant              = grant_q;
    assign o_done               = (state_q == S_RELEASE) ? grant_q : '0;
    assign EXT_MEM_writeAddress = addr_q;
    assign EXT_MEM_writePayload = payload_q;
    assign EXT_MEM_initWriteTxn = (state_q == S_ISSUE);
    assign o_busy               = (state_q != S_IDLE);
    assign o_timeout            = timeout_q;
    assign o_txn_count          = count_q;

endmodule

// File: tb/tb_ext_mem_write_arbiter.sv
// tb/tb_ext_mem_write_arbiter.sv - randomized self-checking bench for ext_mem_write_arbiter
module tb_ext_mem_write_arbiter;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_req;
    logic [32*N-1:0]   i_addr;
    logic [64*N-1:0]   i_payload;
    logic [N-1:0]      o_grant;
    logic [N-1:0]      o_done;
    logic              EXT_MEM_writeTxnDone;
    logic [31:0]       EXT_MEM_writeAddress;
    logic [63:0]       EXT_MEM_writePayload;
    logic              EXT_MEM_initWriteTxn;
    logic              o_busy;
    logic              o_timeout;
    logic [31:0]       o_txn_count;

    ext_mem_write_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_req                (i_req),
        .i_addr               (i_addr),
        .i_payload            (i_payload),
        .o_grant              (o_grant),
        .o_done               (o_done),
        .EXT_MEM_writeTxnDone (EXT_MEM_writeTxnDone),
        .EXT_MEM_writeAddress (EXT_MEM_writeAddress),
        .EXT_MEM_writePayload (EXT_MEM_writePayload),
        .EXT_MEM_initWriteTxn (EXT_MEM_initWriteTxn),
        .o_busy               (o_busy),
        .o_timeout            (o_timeout),
        .o_txn_count          (o_txn_count)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference state
    int m_ptr   = 0;
    int m_count = 0;
    bit m_to    = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_grant"},   o_grant, 0);
        check_eq({tag, "_done"},    o_done, 0);
        check_eq({tag, "_init"},    EXT_MEM_initWriteTxn, 0);
        check_eq({tag, "_addr"},    EXT_MEM_writeAddress, 0);
        check_eq({tag, "_payload"}, EXT_MEM_writePayload, 0);
        check_eq({tag, "_busy"},    o_busy, 0);
        check_eq({tag, "_timeout"}, o_timeout, 0);
        check_eq({tag, "_count"},   o_txn_count, 0);
    endtask

    // Called at a negedge while the DUT is idle with i_req already applied.
    // dly >= 0: done asserted dly cycles after the start pulse; dly < 0: never.
    task automatic run_txn(input int dly, input bit poke);
        int win;
        int c;
        int exp_lat;
        logic [31:0]  ea;
        logic [63:0]  ep;
        logic [N-1:0] oh;
        win = -1;
        for (int i = 0; i < N; i++) begin
            if (win < 0 && i_req[(m_ptr + i) % N]) win = (m_ptr + i) % N;
        end
        if (win < 0) win = 0;
        ea = i_addr[win*32 +: 32];
        ep = i_payload[win*64 +: 64];
        oh = '0;
        oh[win] = 1'b1;
        @(negedge i_clk);
        check_eq("issue_init",    EXT_MEM_initWriteTxn, 1);
        check_eq("issue_grant",   o_grant, oh);
        check_eq("issue_addr",    EXT_MEM_writeAddress, ea);
        check_eq("issue_payload", EXT_MEM_writePayload, ep);
        check_eq("issue_busy",    o_busy, 1);
        c = 0;
        while (o_done == 0 && c < 40) begin
            EXT_MEM_writeTxnDone = (c == dly);
            if (poke && c == 1) i_addr[win*32 +: 32] = ~ea;
            @(negedge i_clk);
            c++;
            if (o_done == 0) begin
                check_eq("wait_no_init",  EXT_MEM_initWriteTxn, 0);
                check_eq("wait_timeout",  o_timeout, m_to);
            end
        end
        EXT_MEM_writeTxnDone = 1'b0;
        exp_lat = (dly >= 0) ? dly + 1 : TMO + 1;
        check_eq("done_latency", c, exp_lat);
        if (dly >= 0) m_count++;
        else m_to = 1'b1;
        check_eq("done_onehot",   o_done, oh);
        check_eq("release_count", o_txn_count, m_count);
        check_eq("release_timeout", o_timeout, m_to);
        check_eq("release_addr_held", EXT_MEM_writeAddress, ea);
        m_ptr = (win + 1) % N;
        @(negedge i_clk);
        check_eq("idle_busy",  o_busy, 0);
        check_eq("idle_grant", o_grant, 0);
        check_eq("idle_done",  o_done, 0);
        check_eq("idle_addr_held", EXT_MEM_writeAddress, ea);
    endtask

    task automatic idle_spurious();
        i_req = '0;
        EXT_MEM_writeTxnDone = 1'b1;
        @(negedge i_clk);
        EXT_MEM_writeTxnDone = 1'b0;
        check_eq("spur_busy",  o_busy, 0);
        check_eq("spur_grant", o_grant, 0);
        check_eq("spur_init",  EXT_MEM_initWriteTxn, 0);
        check_eq("spur_count", o_txn_count, m_count);
        @(negedge i_clk);
        check_eq("spur_busy2", o_busy, 0);
        check_eq("spur_done",  o_done, 0);
    endtask

    task automatic randomize_data();
        for (int k = 0; k < N; k++) begin
            i_addr[k*32 +: 32]    = $urandom;
            i_payload[k*64 +: 64] = {$urandom, $urandom};
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r;
        int d;
        i_rst = 1'b1;
        i_req = '0;
        i_addr = '0;
        i_payload = '0;
        EXT_MEM_writeTxnDone = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_outputs("reset");

        // Single request, done three cycles after the start pulse
        i_addr[31:0]     = 32'h100;
        i_payload[63:0]  = 64'hDEADBEEF_00000001;
        i_req = 2'b01;
        run_txn(3, 1'b0);
        check_eq("t1_count", o_txn_count, 1);

        // Done sampled in the same cycle as the start pulse
        run_txn(0, 1'b0);

        // Watchdog expiry, then a normal transaction with sticky timeout
        i_req = 2'b01;
        run_txn(-1, 1'b0);
        run_txn(2, 1'b0);
        check_eq("timeout_sticky", o_timeout, 1);

        // Spurious done while idle, then input change during WAIT is ignored
        idle_spurious();
        randomize_data();
        i_req = 2'b01;
        run_txn(4, 1'b1);

        // Reset during WAIT abandons the transaction
        i_req = 2'b01;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_req = '0;
        m_ptr = 0; m_count = 0; m_to = 1'b0;
        check_reset_outputs("midrst");
        @(negedge i_clk);
        check_eq("midrst_no_done", o_done, 0);
        check_eq("midrst_idle",    o_busy, 0);
        randomize_data();
        i_req = 2'b10;
        run_txn(1, 1'b0);

        // Continuous contention: strict alternation 0,1,0,1,...
        i_req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            check_eq("contend_ptr_model", m_ptr, t % 2);
            run_txn(2, 1'b0);
        end
        check_eq("contend_count", o_txn_count, 7);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) idle_spurious();
            randomize_data();
            i_req = N'($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            d = (r == 0) ? -1 : int'($urandom_range(0, 4));
            run_txn(d, 1'($urandom_range(0, 1)));
        end
        check_eq("final_count",   o_txn_count, m_count);
        check_eq("final_timeout", o_timeout, m_to);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
